// File: rtl/fdc_disk_server.sv
// fdc_disk_server
//   Sector service engine between the NEC765 FDC core and the host storage
//   controller. Decodes one FDC request at a time from disk_sr, issues a
//   single host transaction for it (read, write, seek or read-id), moves the
//   sector payload between the host byte stream and the FDC FIFOs, and
//   reports done/error/presence/sector-id on disk_cr.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   disk_sr / disk_cr       FDC request word in / status word out
//   disk_data_in/clkin      read byte + 1-cycle strobe into FDC input FIFO
//   disk_data_out/clkout    write byte from FDC output FIFO + 1-cycle pull strobe
//   disk_present            per-drive image mounted (bit0 = A)
//   host_req/op/drive/track/sector   transaction request, held until host_ack
//   host_ack/err            one-cycle completion + error qualifier
//   host_rd_*               read byte stream (valid/ready)
//   host_wr_*               write byte stream (valid/ready)
module fdc_disk_server #(
    parameter int SECTOR_BYTES = 512,
    parameter int PACE         = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disk_sr,
    output logic [31:0] disk_cr,
    output logic [7:0]  disk_data_in,
    output logic        disk_data_clkin,
    input  logic [7:0]  disk_data_out,
    output logic        disk_data_clkout,
    input  logic [1:0]  disk_present,
    output logic        host_req,
    output logic [1:0]  host_op,
    output logic        host_drive,
    output logic [7:0]  host_track,
    output logic [7:0]  host_sector,
    input  logic        host_ack,
    input  logic        host_err,
    input  logic [7:0]  host_rd_data,
    input  logic        host_rd_valid,
    output logic        host_rd_ready,
    output logic [7:0]  host_wr_data,
    output logic        host_wr_valid,
    input  logic        host_wr_ready
);

    localparam int             CW  = 10;
    localparam logic [CW-1:0]  SEC = CW'(SECTOR_BYTES);

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_SK  = 2'd2;
    localparam logic [1:0] OP_RID = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_SEEK, S_RID, S_DONE} state_t;
    // Per-byte write sub-sequence: pull strobe, strobe cycle, capture, hand to host
    typedef enum logic [1:0] {W_PULL, W_STROBE, W_CAPT, W_PUSH} wph_t;

    state_t         state;
    wph_t           wph;
    logic [CW-1:0]  count;
    logic [7:0]     pace_cnt;
    logic [1:0]     rid_hist;
    logic           hist_vld;
    logic           sel;
    logic           is_rid;
    logic           done_q;
    logic           err_q;
    logic [7:0]     sector_id;

    logic           wr_req, rd_req, sk_req, rid_req, lvl_req;
    logic [1:0]     rid_chg;
    logic           req_vld, req_drv;
    logic [1:0]     req_op;
    logic           abort, rd_accept, wr_last;
    logic [CW-1:0]  cnt_inc;
    logic           unused_sr;

    assign unused_sr = ^{disk_sr[31:26], disk_sr[19], disk_sr[16]};

    assign wr_req  = |disk_sr[21:20];
    assign rd_req  = |disk_sr[18:17];
    assign sk_req  = |disk_sr[25:24];
    assign lvl_req = wr_req | rd_req | sk_req;
    // History is invalid for the first cycle after reset so the idle level
    // of the toggle pair is learned rather than seen as a request.
    assign rid_chg = hist_vld ? (disk_sr[23:22] ^ rid_hist) : 2'b00;
    assign rid_req = |rid_chg;

    always_comb begin
        req_vld = 1'b1;
        req_op  = OP_RD;
        req_drv = 1'b0;
        if (wr_req) begin
            req_op  = OP_WR;
            req_drv = disk_sr[21];
        end else if (rd_req) begin
            req_op  = OP_RD;
            req_drv = disk_sr[18];
        end else if (sk_req) begin
            req_op  = OP_SK;
            req_drv = disk_sr[25];
        end else if (rid_req) begin
            req_op  = OP_RID;
            req_drv = rid_chg[1];
        end else begin
            req_vld = 1'b0;
        end
    end

    // FDC dropped its level request mid-transaction (FDC reset)
    assign abort = ((state == S_READ)  && !rd_req) ||
                   ((state == S_WRITE) && !wr_req) ||
                   ((state == S_SEEK)  && !sk_req);

    assign host_rd_ready = (state == S_READ) && (count < SEC) && (pace_cnt == 8'd0);
    assign rd_accept     = host_rd_valid && host_rd_ready;
    assign cnt_inc       = count + CW'(1);
    // Final write byte handed over in the same cycle as host_ack
    assign wr_last       = (wph == W_PUSH) && host_wr_valid && host_wr_ready && (cnt_inc == SEC);

    assign disk_cr = {sector_id, 18'd0, disk_present[sel], done_q, err_q, 3'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            wph              <= W_PULL;
            count            <= '0;
            pace_cnt         <= 8'd0;
            rid_hist         <= 2'b00;
            hist_vld         <= 1'b0;
            sel              <= 1'b0;
            is_rid           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            sector_id        <= 8'd0;
            host_req         <= 1'b0;
            host_op          <= OP_RD;
            host_drive       <= 1'b0;
            host_track       <= 8'd0;
            host_sector      <= 8'd0;
            host_wr_data     <= 8'd0;
            host_wr_valid    <= 1'b0;
            disk_data_in     <= 8'd0;
            disk_data_clkin  <= 1'b0;
            disk_data_clkout <= 1'b0;
        end else begin
            disk_data_clkin  <= 1'b0;
            disk_data_clkout <= 1'b0;
            rid_hist         <= disk_sr[23:22];
            hist_vld         <= 1'b1;
            if (pace_cnt != 8'd0)
                pace_cnt <= pace_cnt - 8'd1;

            if (abort) begin
                host_req      <= 1'b0;
                host_wr_valid <= 1'b0;
                state         <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        count <= '0;
                        wph   <= W_PULL;
                        if (req_vld) begin
                            sel         <= req_drv;
                            host_drive  <= req_drv;
                            host_op     <= req_op;
                            host_track  <= {disk_sr[14:8], disk_sr[15]};
                            host_sector <= disk_sr[7:0];
                            is_rid      <= (req_op == OP_RID);
                            if (!disk_present[req_drv]) begin
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                host_req <= 1'b1;
                                case (req_op)
                                    OP_RD:   state <= S_READ;
                                    OP_WR:   state <= S_WRITE;
                                    OP_SK:   state <= S_SEEK;
                                    default: state <= S_RID;
                                endcase
                            end
                        end
                    end

                    S_READ: begin
                        if (rd_accept) begin
                            disk_data_in    <= host_rd_data;
                            disk_data_clkin <= 1'b1;
                            count           <= cnt_inc;
                            pace_cnt        <= 8'(PACE);
                        end
                        if (host_ack) begin
                            host_req <= 1'b0;
                            done_q   <= 1'b1;
                            err_q    <= host_err | ((rd_accept ? cnt_inc : count) != SEC);
                            state    <= S_DONE;
                        end
                    end

                    S_WRITE: begin
                        if (host_ack) begin
                            host_req      <= 1'b0;
                            host_wr_valid <= 1'b0;
                            done_q        <= 1'b1;
                            err_q         <= host_err | !((count == SEC) || wr_last);
                            state         <= S_DONE;
                        end else if (count != SEC) begin
                            case (wph)
                                W_PULL: begin
                                    disk_data_clkout <= 1'b1;
                                    wph              <= W_STROBE;
                                end
                                W_STROBE: wph <= W_CAPT;
                                W_CAPT: begin
                                    host_wr_data  <= disk_data_out;
                                    host_wr_valid <= 1'b1;
                                    wph           <= W_PUSH;
                                end
                                default: begin
                                    if (host_wr_ready) begin
                                        host_wr_valid <= 1'b0;
                                        count         <= cnt_inc;
                                        wph           <= W_PULL;
                                    end
                                end
                            endcase
                        end
                    end

                    S_SEEK, S_RID: begin
                        if (host_ack) begin
                            host_req <= 1'b0;
                            done_q   <= 1'b1;
                            err_q    <= host_err;
                            if (state == S_RID && !host_err)
                                sector_id <= host_rd_data;
                            state    <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        // Read-id has no level to wait on: done is a 1-cycle pulse
                        if (is_rid || !lvl_req) begin
                            done_q <= 1'b0;
                            err_q  <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fdc_disk_server.sv
module tb_fdc_disk_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] disk_sr;
    logic [31:0] disk_cr;
    logic [7:0]  disk_data_in;
    logic        disk_data_clkin;
    logic [7:0]  disk_data_out;
    logic        disk_data_clkout;
    logic [1:0]  disk_present;
    logic        host_req;
    logic [1:0]  host_op;
    logic        host_drive;
    logic [7:0]  host_track;
    logic [7:0]  host_sector;
    logic        host_ack;
    logic        host_err;
    logic [7:0]  host_rd_data;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic [7:0]  host_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;

    fdc_disk_server #(.SECTOR_BYTES(512), .PACE(0)) dut (
        .clk(clk), .rst_n(rst_n), .disk_sr(disk_sr), .disk_cr(disk_cr),
        .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
        .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
        .disk_present(disk_present), .host_req(host_req), .host_op(host_op),
        .host_drive(host_drive), .host_track(host_track), .host_sector(host_sector),
        .host_ack(host_ack), .host_err(host_err), .host_rd_data(host_rd_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
        .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid),
        .host_wr_ready(host_wr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sr;
        logic [1:0]  pres;
        logic        req;
        logic [1:0]  op;
        logic        drv;
        logic [7:0]  trk;
        logic [7:0]  sec;
    } vec_t;

    vec_t       vt[10];
    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] fifo[512];
    int         fptr = 0;
    bit         pend = 0;
    bit         wr_tog = 0;
    int         clkin_cnt = 0;
    int         clkout_cnt = 0;
    int         wr_hs = 0;
    logic [1:0] rid_bits = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_sr(input logic [1:0] rd, input logic [1:0] wr,
                                          input logic [1:0] sk, input logic [6:0] cyl,
                                          input logic hd, input logic [7:0] sec);
        logic [31:0] v;
        v = 32'd0;
        v[7:0]   = sec;
        v[14:8]  = cyl;
        v[15]    = hd;
        v[18:17] = rd;
        v[21:20] = wr;
        v[25:24] = sk;
        return v;
    endfunction

    task automatic drive_sr(input logic [31:0] v);
        disk_sr = {v[31:24], rid_bits, v[21:0]};
    endtask

    // One clock step, sampled on the falling edge. Also models the FDC output
    // FIFO (byte valid the cycle after clkout) and the host write sink.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (disk_data_clkin) begin
            clkin_cnt++;
            if (rd_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL clkin_unexpected: byte 0x%0h, none outstanding", disk_data_in);
            end else begin
                e = rd_q.pop_front();
                check("clkin_data", {24'd0, disk_data_in}, {24'd0, e});
            end
        end
        if (pend) begin
            e = (fptr < 512) ? fifo[fptr] : 8'h00;
            disk_data_out = e;
            wr_q.push_back(e);
            fptr++;
            pend = 0;
        end
        if (disk_data_clkout) begin
            clkout_cnt++;
            disk_data_out = 8'($urandom);
            pend = 1;
        end
        host_wr_ready = wr_tog ? ~host_wr_ready : 1'b0;
        if (host_wr_valid && host_wr_ready) begin
            wr_hs++;
            if (wr_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL wr_unexpected: host byte 0x%0h, none outstanding", host_wr_data);
            end else begin
                e = wr_q.pop_front();
                check("wr_data", {24'd0, host_wr_data}, {24'd0, e});
            end
        end
    endtask

    task automatic stream_rd(input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 4 * n + 20) begin
            host_rd_valid = 1'b1;
            host_rd_data  = 8'(sent);
            if (host_rd_ready) begin
                rd_q.push_back(8'(sent));
                sent++;
            end
            tick();
            guard++;
        end
        host_rd_valid = 1'b0;
        check("rd_stream_len", sent, n);
    endtask

    task automatic chk_zero_outs(input string tag);
        check({tag, "_req"},   {31'd0, host_req}, 32'd0);
        check({tag, "_wrv"},   {31'd0, host_wr_valid}, 32'd0);
        check({tag, "_rdy"},   {31'd0, host_rd_ready}, 32'd0);
        check({tag, "_clkin"}, {31'd0, disk_data_clkin}, 32'd0);
        check({tag, "_clkout"},{31'd0, disk_data_clkout}, 32'd0);
        check({tag, "_cr"},    disk_cr, 32'd0);
    endtask

    initial begin
        vt[0] = '{mk_sr(2'b01, 2'b00, 2'b00, 7'd3,   1'b0, 8'hC1), 2'b11, 1'b1, 2'd0, 1'b0, 8'h06, 8'hC1};
        vt[1] = '{mk_sr(2'b10, 2'b00, 2'b00, 7'd5,   1'b1, 8'h02), 2'b11, 1'b1, 2'd0, 1'b1, 8'h0B, 8'h02};
        vt[2] = '{mk_sr(2'b11, 2'b00, 2'b00, 7'd0,   1'b0, 8'h01), 2'b11, 1'b1, 2'd0, 1'b1, 8'h00, 8'h01};
        vt[3] = '{mk_sr(2'b10, 2'b01, 2'b00, 7'd2,   1'b0, 8'h03), 2'b11, 1'b1, 2'd1, 1'b0, 8'h04, 8'h03};
        vt[4] = '{mk_sr(2'b01, 2'b00, 2'b10, 7'd7,   1'b1, 8'h09), 2'b11, 1'b1, 2'd0, 1'b0, 8'h0F, 8'h09};
        vt[5] = '{mk_sr(2'b00, 2'b00, 2'b01, 7'd40,  1'b1, 8'h00), 2'b11, 1'b1, 2'd2, 1'b0, 8'h51, 8'h00};
        vt[6] = '{mk_sr(2'b00, 2'b10, 2'b00, 7'd127, 1'b1, 8'hFF), 2'b11, 1'b1, 2'd1, 1'b1, 8'hFF, 8'hFF};
        vt[7] = '{mk_sr(2'b00, 2'b00, 2'b11, 7'd1,   1'b0, 8'h10), 2'b11, 1'b1, 2'd2, 1'b1, 8'h02, 8'h10};
        vt[8] = '{mk_sr(2'b01, 2'b00, 2'b00, 7'd1,   1'b0, 8'h01), 2'b10, 1'b0, 2'd0, 1'b0, 8'h02, 8'h01};
        vt[9] = '{mk_sr(2'b10, 2'b00, 2'b00, 7'd1,   1'b0, 8'h01), 2'b01, 1'b0, 2'd0, 1'b1, 8'h02, 8'h01};

        rst_n = 1'b0;
        disk_sr = 32'd0;
        disk_present = 2'b00;
        disk_data_out = 8'd0;
        host_ack = 1'b0; host_err = 1'b0;
        host_rd_data = 8'd0; host_rd_valid = 1'b0;
        host_wr_ready = 1'b0;
        #3;
        chk_zero_outs("reset");
        tick(); tick();
        rst_n = 1'b1;
        disk_present = 2'b11;
        tick(); tick();

        // Decode table: priority, drive selection, track math, missing disk
        for (int i = 0; i < 10; i++) begin
            disk_present = vt[i].pres;
            drive_sr(vt[i].sr);
            tick();
            check($sformatf("v%0d_req", i), {31'd0, host_req}, {31'd0, vt[i].req});
            if (vt[i].req) begin
                check($sformatf("v%0d_op", i),  {30'd0, host_op}, {30'd0, vt[i].op});
                check($sformatf("v%0d_drv", i), {31'd0, host_drive}, {31'd0, vt[i].drv});
                check($sformatf("v%0d_trk", i), {24'd0, host_track}, {24'd0, vt[i].trk});
                check($sformatf("v%0d_sec", i), {24'd0, host_sector}, {24'd0, vt[i].sec});
                check($sformatf("v%0d_cr", i),  {29'd0, disk_cr[5:3]}, {29'd0, vt[i].pres[vt[i].drv], 2'b00});
            end else begin
                check($sformatf("v%0d_cr", i),  {29'd0, disk_cr[5:3]}, {29'd0, 3'b011});
            end
            drive_sr(32'd0);
            tick();
            check($sformatf("v%0d_drop_req", i), {31'd0, host_req}, 32'd0);
            check($sformatf("v%0d_drop_done", i), {31'd0, disk_cr[4]}, 32'd0);
            tick();
        end
        disk_present = 2'b11;
        check("no_stray_clkout", clkout_cnt, 0);

        // Full sector read on drive A
        clkin_cnt = 0;
        drive_sr(mk_sr(2'b01, 2'b00, 2'b00, 7'd3, 1'b0, 8'hC1));
        tick();
        check("rd_op", {30'd0, host_op}, 32'd0);
        check("rd_trk", {24'd0, host_track}, 32'h06);
        check("rd_sec", {24'd0, host_sector}, 32'hC1);
        stream_rd(512);
        host_rd_valid = 1'b1;
        host_rd_data = 8'hEE;
        check("rd_full_rdy", {31'd0, host_rd_ready}, 32'd0);
        tick(); tick();
        host_rd_valid = 1'b0;
        check("rd_clkin_cnt", clkin_cnt, 512);
        host_ack = 1'b1; host_err = 1'b0;
        tick();
        host_ack = 1'b0;
        check("rd_done", {29'd0, disk_cr[5:3]}, 32'b110);
        check("rd_req_low", {31'd0, host_req}, 32'd0);
        tick();
        check("rd_done_hold", {31'd0, disk_cr[4]}, 32'd1);
        drive_sr(32'd0);
        tick();
        check("rd_done_clr", {31'd0, disk_cr[4]}, 32'd0);
        check("rd_q_empty", rd_q.size(), 0);

        // Short read: host acks after 100 bytes
        clkin_cnt = 0;
        drive_sr(mk_sr(2'b01, 2'b00, 2'b00, 7'd1, 1'b0, 8'h01));
        tick();
        stream_rd(100);
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        check("short_cr", {30'd0, disk_cr[4:3]}, 32'b11);
        check("short_clkin", clkin_cnt, 100);
        drive_sr(32'd0);
        tick();
        check("short_clr", {30'd0, disk_cr[4:3]}, 32'd0);

        // Seek A to cylinder 40 with host error
        drive_sr(mk_sr(2'b00, 2'b00, 2'b01, 7'd40, 1'b0, 8'h00));
        tick();
        check("sk_op", {30'd0, host_op}, 32'd2);
        check("sk_trk", {24'd0, host_track}, 32'd80);
        tick(); tick();
        host_ack = 1'b1; host_err = 1'b1;
        tick();
        host_ack = 1'b0; host_err = 1'b0;
        check("sk_cr", {30'd0, disk_cr[4:3]}, 32'b11);
        tick(); tick();
        check("sk_cr_hold", {30'd0, disk_cr[4:3]}, 32'b11);
        drive_sr(32'd0);
        tick();
        check("sk_cr_clr", {30'd0, disk_cr[4:3]}, 32'd0);

        // Read-id on drive A via toggle of sr[22]
        rid_bits[0] = ~rid_bits[0];
        drive_sr(32'd0);
        tick();
        check("rid_req", {31'd0, host_req}, 32'd1);
        check("rid_op", {30'd0, host_op}, 32'd3);
        check("rid_drv", {31'd0, host_drive}, 32'd0);
        host_ack = 1'b1; host_rd_data = 8'hC5;
        tick();
        host_ack = 1'b0;
        check("rid_done", {31'd0, disk_cr[4]}, 32'd1);
        check("rid_id", {24'd0, disk_cr[31:24]}, 32'hC5);
        tick();
        check("rid_pulse", {31'd0, disk_cr[4]}, 32'd0);
        check("rid_id_keep", {24'd0, disk_cr[31:24]}, 32'hC5);

        // No disk mounted: immediate error, no host transaction
        disk_present = 2'b00;
        drive_sr(mk_sr(2'b01, 2'b00, 2'b00, 7'd2, 1'b0, 8'h05));
        tick();
        check("nodisk_req", {31'd0, host_req}, 32'd0);
        check("nodisk_cr", {29'd0, disk_cr[5:3]}, 32'b011);
        drive_sr(32'd0);
        disk_present = 2'b11;
        tick();
        check("nodisk_clr", {31'd0, disk_cr[4]}, 32'd0);

        // FDC abort after 50 read bytes
        clkin_cnt = 0;
        drive_sr(mk_sr(2'b01, 2'b00, 2'b00, 7'd4, 1'b0, 8'h07));
        tick();
        stream_rd(50);
        drive_sr(32'd0);
        host_rd_valid = 1'b1;
        tick();
        check("abort_req", {31'd0, host_req}, 32'd0);
        repeat (4) tick();
        host_rd_valid = 1'b0;
        check("abort_clkin", clkin_cnt, 50);
        check("abort_done", {31'd0, disk_cr[4]}, 32'd0);
        check("abort_rdy", {31'd0, host_rd_ready}, 32'd0);

        // Full sector write on drive B, host ready toggling
        for (int i = 0; i < 512; i++) fifo[i] = 8'($urandom);
        fptr = 0; clkout_cnt = 0; wr_hs = 0;
        wr_tog = 1;
        drive_sr(mk_sr(2'b00, 2'b10, 2'b00, 7'd10, 1'b1, 8'h05));
        tick();
        check("wr_op", {30'd0, host_op}, 32'd1);
        check("wr_drv", {31'd0, host_drive}, 32'd1);
        check("wr_trk", {24'd0, host_track}, 32'd21);
        for (int g = 0; g < 6000 && wr_hs < 512; g++) tick();
        check("wr_hs_cnt", wr_hs, 512);
        tick(); tick(); tick(); tick();
        check("wr_clkout_cnt", clkout_cnt, 512);
        check("wr_valid_idle", {31'd0, host_wr_valid}, 32'd0);
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        check("wr_cr", {30'd0, disk_cr[4:3]}, 32'b10);
        wr_tog = 0;
        check("wr_q_empty", wr_q.size(), 0);
        drive_sr(32'd0);
        tick();
        check("wr_cr_clr", {31'd0, disk_cr[4]}, 32'd0);

        // Asynchronous reset in the middle of a write
        fptr = 0;
        wr_tog = 1;
        drive_sr(mk_sr(2'b00, 2'b10, 2'b00, 7'd3, 1'b0, 8'h01));
        repeat (20) tick();
        disk_present = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outs("midrst");
        wr_tog = 0;
        drive_sr(32'd0);
        tick(); tick();
        rst_n = 1'b1;
        wr_q.delete();
        pend = 0;
        disk_present = 2'b11;
        tick(); tick();
        check("post_rst_req", {31'd0, host_req}, 32'd0);
        check("post_rst_cr", {30'd0, disk_cr[4:3]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
